seven_seg_scanner: RTL and testbench

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_scanner.sv | 105 ++++++++++
 tb/tb_seven_seg_scanner.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Multiplexed 4-digit seven-segment scanner, stepped by rising edges of a divided scan clock.
// Optional leading-zero blanking when SEG_LZB_EN is defined.
module seven_seg_scanner (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_clk,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    logic        s1;
    logic        s2;
    logic        s3;
    logic        step;
    logic [1:0]  digit;
    logic [1:0]  nxt;
    logic        wrap;
    logic [15:0] shadow_val;
    logic [3:0]  shadow_dp;
    logic [3:0]  nib;
    logic        dp_bit;
    logic [6:0]  seg_next;
    logic [3:0]  an_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign step = s2 & ~s3;

    // On the wrapping step digit 0 is decoded straight from the incoming value,
    // so the new frame shows without a one-frame lag.
    always_comb begin
        nxt      = digit + 2'd1;
        wrap     = (digit == 2'd3);
        nib      = wrap ? value[3:0] : shadow_val[{nxt, 2'b00} +: 4];
        dp_bit   = wrap ? dp_in[0] : shadow_dp[nxt];
        seg_next = hex_to_seg(nib);
        an_next  = 4'hF;
        an_next[nxt] = 1'b0;
`ifdef SEG_LZB_EN
        case (nxt)
            2'd1:    if (shadow_val[15:4] == 12'h000) seg_next = 7'h7F;
            2'd2:    if (shadow_val[15:8] == 8'h00) seg_next = 7'h7F;
            2'd3:    if (shadow_val[15:12] == 4'h0) seg_next = 7'h7F;
            default: ;
        endcase
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            digit       <= 2'd3;
            an          <= 4'hF;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
            shadow_val  <= 16'h0000;
            shadow_dp   <= 4'h0;
        end else begin
            s1          <= scan_clk;
            s2          <= s1;
            s3          <= s2;
            frame_start <= 1'b0;
            if (step) begin
                digit <= nxt;
                an    <= an_next;
                seg   <= seg_next;
                dp    <= ~dp_bit;
                if (wrap) begin
                    shadow_val  <= value;
                    shadow_dp   <= dp_in;
                    frame_start <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomised + directed bench for seven_seg_scanner with a per-cycle behavioural reference.
module tb_seven_seg_scanner;

`ifdef SEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    localparam logic [6:0] BLANK_OR_ZERO = LZB ? 7'h7F : 7'h40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scan_clk = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    seven_seg_scanner dut (
        .clk(clk), .rst(rst), .scan_clk(scan_clk), .value(value), .dp_in(dp_in),
        .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Reference model: scan history as a plain sample delay line, digit as an integer.
    logic [6:0]  seg_tbl [16];
    bit          hist [3];
    int          m_digit;
    logic [15:0] m_val;
    logic [3:0]  m_dpsh;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;
    logic        m_dp;
    logic        m_fs;

    initial begin
        seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    end

    always @(posedge clk) begin
        if (rst) begin
            hist = '{0, 0, 0};
            m_digit = 3; m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1; m_fs = 1'b0;
            m_val = 16'h0; m_dpsh = 4'h0;
        end else begin
            bit stp;
            stp = hist[1] && !hist[2];
            m_fs = 1'b0;
            if (stp) begin
                m_digit = (m_digit + 1) % 4;
                if (m_digit == 0) begin
                    m_val = value; m_dpsh = dp_in; m_fs = 1'b1;
                end
                m_an = 4'hF;
                m_an[m_digit] = 1'b0;
                m_seg = seg_tbl[(m_val >> (4 * m_digit)) & 16'hF];
                if (LZB && m_digit > 0 && (m_val >> (4 * m_digit)) == 0)
                    m_seg = 7'h7F;
                m_dp = ~m_dpsh[m_digit];
            end
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = scan_clk;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_an", an, m_an);
            check("model_seg", seg, m_seg);
            check("model_dp", dp, m_dp);
            check("model_fs", frame_start, m_fs);
        end
    end

    // One scan_clk pulse (4 high, 4 low), then literal checks of the settled outputs.
    task automatic pulse(input string name, input logic [3:0] ean, input logic [6:0] eseg,
                         input logic edp, input int efs);
        int fs_cnt = 0;
        scan_clk = 1'b1;
        repeat (4) begin @(negedge clk); fs_cnt += frame_start; end
        scan_clk = 1'b0;
        repeat (4) begin @(negedge clk); fs_cnt += frame_start; end
        check({name, "_an"}, an, ean);
        check({name, "_seg"}, seg, eseg);
        check({name, "_dp"}, dp, edp);
        check({name, "_fs"}, fs_cnt, efs);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1);
        check("rst_fs", frame_start, 0);
        value = 16'h1234;
        rst = 1'b0;
        @(negedge clk);
        pulse("p1", 4'hE, 7'h19, 1, 1);
        pulse("p2", 4'hD, 7'h30, 1, 0);
        pulse("p3", 4'hB, 7'h24, 1, 0);
        pulse("p4", 4'h7, 7'h79, 1, 0);
        pulse("p5", 4'hE, 7'h19, 1, 1);
        pulse("p6", 4'hD, 7'h30, 1, 0);
        value = 16'hABCD;
        pulse("mid2", 4'hB, 7'h24, 1, 0);
        pulse("mid3", 4'h7, 7'h79, 1, 0);
        pulse("newf0", 4'hE, 7'h21, 1, 1);
        value = 16'h0005;
        pulse("p10", 4'hD, 7'h46, 1, 0);
        pulse("p11", 4'hB, 7'h03, 1, 0);
        pulse("p12", 4'h7, 7'h08, 1, 0);
        pulse("z0", 4'hE, 7'h12, 1, 1);
        pulse("z1", 4'hD, BLANK_OR_ZERO, 1, 0);
        pulse("z2", 4'hB, BLANK_OR_ZERO, 1, 0);
        pulse("z3", 4'h7, BLANK_OR_ZERO, 1, 0);
        pulse("z0b", 4'hE, 7'h12, 1, 1);
        dp_in = 4'b0100;
        pulse("p18", 4'hD, BLANK_OR_ZERO, 1, 0);
        pulse("p19", 4'hB, BLANK_OR_ZERO, 1, 0);
        pulse("p20", 4'h7, BLANK_OR_ZERO, 1, 0);
        pulse("p21", 4'hE, 7'h12, 1, 1);
        pulse("dp1", 4'hD, BLANK_OR_ZERO, 1, 0);
        pulse("dp2", 4'hB, BLANK_OR_ZERO, 0, 0);
        pulse("dp3", 4'h7, BLANK_OR_ZERO, 1, 0);
        pulse("dp0", 4'hE, 7'h12, 1, 1);
        scan_clk = 1'b1;
        repeat (1000) @(negedge clk);
        check("hold_an", an, 4'hD);
        check("hold_seg", seg, BLANK_OR_ZERO);
        check("hold_dp", dp, 1);
        scan_clk = 1'b0;
        repeat (4) @(negedge clk);
        pulse("to2", 4'hB, BLANK_OR_ZERO, 0, 0);
        // Reset lands on the very edge where the step at digit 2 would fire.
        scan_clk = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rststep_an", an, 4'hF);
        check("rststep_seg", seg, 7'h7F);
        check("rststep_fs", frame_start, 0);
        rst = 1'b0;
        scan_clk = 1'b0;
        repeat (4) @(negedge clk);
        pulse("restart", 4'hE, 7'h12, 1, 1);

        for (int i = 0; i < 400; i++) begin
            scan_clk = $urandom_range(1, 0);
            if ($urandom_range(3, 0) == 0) value = 16'($urandom);
            if ($urandom_range(3, 0) == 0) dp_in = 4'($urandom);
            if ($urandom_range(6, 0) == 0) value = {4'h0, 4'($urandom), 8'($urandom)} >> (4 * $urandom_range(3, 0));
            rst = ($urandom_range(60, 0) == 0);
            repeat ($urandom_range(5, 1)) @(negedge clk);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
